// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings plus burst helpers for the address-phase sequencer.
package ahb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } trans_type;

  typedef enum logic [2:0] {
    SINGLE = 3'd0,
    INCR   = 3'd1,
    WRAP4  = 3'd2,
    INCR4  = 3'd3,
    WRAP8  = 3'd4,
    INCR8  = 3'd5,
    WRAP16 = 3'd6,
    INCR16 = 3'd7
  } burst_type;

  typedef enum logic [2:0] {
    BYTE      = 3'd0,
    HALF_WORD = 3'd1,
    WORD      = 3'd2,
    DWORD     = 3'd3,
    WORD4     = 3'd4,
    WORD8     = 3'd5,
    WORD16    = 3'd6,
    WORD32    = 3'd7
  } size_type;

  typedef enum logic [1:0] {
    G_IDLE   = 2'd0,
    G_ACTIVE = 2'd1,
    G_BSY    = 2'd2,
    G_ABORT  = 2'd3
  } gen_state;

  localparam int BOUNDARY_1KB = 1024;
  localparam int BEAT_W       = 5;

  // Undefined-length INCR takes its count from len; fixed bursts ignore it.
  function automatic logic [BEAT_W-1:0] burst_beats(burst_type burst, logic [BEAT_W-1:0] len);
    case (burst)
      SINGLE:        return BEAT_W'(1);
      INCR:          return len;
      WRAP4, INCR4:  return BEAT_W'(4);
      WRAP8, INCR8:  return BEAT_W'(8);
      default:       return BEAT_W'(16);
    endcase
  endfunction

endpackage

// File: rtl/ahb_next_addr.sv
// Combinational next-beat address for INCR/WRAP bursts, plus a flag when the
// step leaves the current BOUNDARY-sized region.
module ahb_next_addr
  import ahb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int BOUNDARY   = BOUNDARY_1KB
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [2:0]            burst,
  input  logic [2:0]            size,
  output logic [ADDR_WIDTH-1:0] next_addr,
  output logic                  boundary_cross
);

  localparam logic [ADDR_WIDTH-1:0] BND_MASK = ADDR_WIDTH'(BOUNDARY - 1);

  logic [ADDR_WIDTH-1:0] step;
  logic [ADDR_WIDTH-1:0] inc_addr;
  logic [ADDR_WIDTH-1:0] wrap_mask;

  always_comb begin
    step      = ADDR_WIDTH'(1) << size;
    inc_addr  = addr + step;
    wrap_mask = (ADDR_WIDTH'(burst_beats(burst_type'(burst), BEAT_W'(0))) << size) - ADDR_WIDTH'(1);
    if (burst inside {WRAP4, WRAP8, WRAP16})
      next_addr = (addr & ~wrap_mask) | (inc_addr & wrap_mask);
    else
      next_addr = inc_addr;
    boundary_cross = (next_addr & ~BND_MASK) != (addr & ~BND_MASK);
  end

endmodule

// File: rtl/ahb_burst_addr_gen.sv
// AHB-Lite master address-phase sequencer: one burst per req handshake, NONSEQ one cycle after accept.
// Outputs hold while HREADY=0; req_ready only in IDLE, so a new burst always follows at least one IDLE cycle.
module ahb_burst_addr_gen
  import ahb_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MAX_INCR_LEN = 16,
  parameter int BOUNDARY     = BOUNDARY_1KB,
  localparam int LEN_W       = $clog2(MAX_INCR_LEN) + 1
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  req_write,
  input  logic [2:0]            req_burst,
  input  logic [2:0]            req_size,
  input  logic [LEN_W-1:0]      req_len,
  input  logic                  beat_hold,
  input  logic                  HREADY,
  input  logic                  HRESP,
  output logic [ADDR_WIDTH-1:0] HADDR,
  output logic [1:0]            HTRANS,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic                  done,
  output logic                  err
);

  gen_state              state;
  logic [BEAT_W-1:0]     cnt;
  logic [BEAT_W-1:0]     beats;
  logic                  xing;

  logic [ADDR_WIDTH-1:0] nxt_addr;
  logic                  nxt_cross_raw;
  logic                  nxt_cross;
  logic                  last_beat;

  logic [ADDR_WIDTH-1:0] req_bytes;
  logic [ADDR_WIDTH-1:0] req_span;
  logic [ADDR_WIDTH-1:0] req_off;
  logic [BEAT_W-1:0]     req_beats;
  logic                  req_legal;

  ahb_next_addr #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .BOUNDARY   (BOUNDARY)
  ) u_next (
    .addr           (HADDR),
    .burst          (HBURST),
    .size           (HSIZE),
    .next_addr      (nxt_addr),
    .boundary_cross (nxt_cross_raw)
  );

  // Only undefined-length INCR may cross; fixed bursts are rejected up front if they would.
  assign nxt_cross = nxt_cross_raw && (HBURST == INCR);
  assign last_beat = (cnt == beats - BEAT_W'(1));
  assign req_ready = (state == G_IDLE);

  always_comb begin
    req_bytes = ADDR_WIDTH'(1) << req_size;
    req_beats = burst_beats(burst_type'(req_burst), BEAT_W'(req_len));
    req_span  = ADDR_WIDTH'(req_beats) << req_size;
    req_off   = req_addr & ADDR_WIDTH'(BOUNDARY - 1);
    req_legal = 1'b1;
    if ((req_addr & (req_bytes - ADDR_WIDTH'(1))) != '0)
      req_legal = 1'b0;
    if (req_bytes > ADDR_WIDTH'(DATA_WIDTH / 8))
      req_legal = 1'b0;
    if ((req_burst == INCR) && ((req_len == '0) || (req_len > LEN_W'(MAX_INCR_LEN))))
      req_legal = 1'b0;
    if ((req_burst inside {INCR4, INCR8, INCR16}) && (req_off + req_span > ADDR_WIDTH'(BOUNDARY)))
      req_legal = 1'b0;
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state  <= G_IDLE;
      HADDR  <= '0;
      HTRANS <= IDLE;
      HWRITE <= 1'b0;
      HSIZE  <= BYTE;
      HBURST <= SINGLE;
      done   <= 1'b0;
      err    <= 1'b0;
      cnt    <= '0;
      beats  <= '0;
      xing   <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        G_IDLE: begin
          if (req_valid) begin
            if (!req_legal) begin
              err <= 1'b1;
            end else begin
              HADDR  <= req_addr;
              HTRANS <= NONSEQ;
              HWRITE <= req_write;
              HSIZE  <= req_size;
              HBURST <= req_burst;
              beats  <= req_beats;
              cnt    <= '0;
              state  <= G_ACTIVE;
            end
          end
        end
        G_ACTIVE: begin
          if (HRESP && !HREADY) begin
            HTRANS <= IDLE;
            err    <= 1'b1;
            state  <= G_ABORT;
          end else if (HREADY) begin
            cnt <= cnt + BEAT_W'(1);
            if (last_beat) begin
              HTRANS <= IDLE;
              done   <= 1'b1;
              state  <= G_IDLE;
            end else begin
              HADDR <= nxt_addr;
              if (beat_hold) begin
                // Remember the crossing so the resumed beat still restarts as NONSEQ.
                HTRANS <= BUSY;
                xing   <= nxt_cross;
                state  <= G_BSY;
              end else begin
                HTRANS <= nxt_cross ? NONSEQ : SEQ;
              end
            end
          end
        end
        G_BSY: begin
          if (HRESP && !HREADY) begin
            HTRANS <= IDLE;
            err    <= 1'b1;
            state  <= G_ABORT;
          end else if (HREADY && !beat_hold) begin
            HTRANS <= xing ? NONSEQ : SEQ;
            state  <= G_ACTIVE;
          end
        end
        G_ABORT: begin
          if (HREADY)
            state <= G_IDLE;
        end
        default: state <= G_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_burst_addr_gen.sv
// Bench for ahb_burst_addr_gen: directed scenarios plus randomized bursts checked
// against an arithmetic model of the beat address/transfer-type sequence.
module tb_ahb_burst_addr_gen;
  import ahb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int ML = 16;
  localparam int LW = $clog2(ML) + 1;

  logic          HCLK = 1'b0;
  logic          HRESETn, req_valid, req_ready, req_write, beat_hold;
  logic          HREADY, HRESP, HWRITE, done, err;
  logic [AW-1:0] req_addr, HADDR;
  logic [2:0]    req_burst, req_size, HSIZE, HBURST;
  logic [LW-1:0] req_len;
  logic [1:0]    HTRANS;

  int passed = 0;
  int total  = 0;

  ahb_burst_addr_gen #(
    .ADDR_WIDTH   (AW),
    .DATA_WIDTH   (DW),
    .MAX_INCR_LEN (ML),
    .BOUNDARY     (1024)
  ) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_write (req_write),
    .req_burst (req_burst),
    .req_size  (req_size),
    .req_len   (req_len),
    .beat_hold (beat_hold),
    .HREADY    (HREADY),
    .HRESP     (HRESP),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HSIZE     (HSIZE),
    .HBURST    (HBURST),
    .done      (done),
    .err       (err)
  );

  always #5 HCLK = ~HCLK;

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  // Reference model: beat k of a burst, straight from the burst rules.
  function automatic int nbeats(int b, int len);
    case (b)
      0:       return 1;
      1:       return len;
      2, 3:    return 4;
      4, 5:    return 8;
      default: return 16;
    endcase
  endfunction

  function automatic logic [31:0] model_addr(logic [31:0] start, int b, int sz, int k);
    int unsigned bytes, wb, base;
    bytes = 32'd1 << sz;
    if (b == 2 || b == 4 || b == 6) begin
      wb   = nbeats(b, 0) * bytes;
      base = start - (start % wb);
      return base + ((start - base + k * bytes) % wb);
    end
    return start + k * bytes;
  endfunction

  function automatic logic [1:0] model_trans(logic [31:0] start, int b, int sz, int k);
    if (k == 0) return 2'b10;
    if (b == 1 && (model_addr(start, b, sz, k) / 1024) != (model_addr(start, b, sz, k - 1) / 1024))
      return 2'b10;
    return 2'b11;
  endfunction

  task automatic send_req(input logic [31:0] a, input int b, input int sz, input int len, input logic wr);
    req_valid = 1'b1; req_addr = a; req_burst = 3'(b); req_size = 3'(sz);
    req_len = LW'(len); req_write = wr;
    step();
    req_valid = 1'b0;
  endtask

  task automatic run_burst(input logic [31:0] start, input int b, input int sz, input int len,
                           input logic wr, input int stall_pct, input int hold_pct);
    int nb, k, cyc;
    logic [31:0] ea;
    logic [1:0] et;
    nb = nbeats(b, len); k = 0; cyc = 0;
    total++;
    if (req_ready !== 1'b1) $display("FAIL burst_ready: req_ready=%b want 1", req_ready);
    else passed++;
    HREADY = 1'b1; beat_hold = 1'b0; HRESP = 1'b0;
    send_req(start, b, sz, len, wr);
    while (k < nb && cyc < 2000) begin
      ea = model_addr(start, b, sz, k);
      et = model_trans(start, b, sz, k);
      total++;
      if (HTRANS == 2'b01) begin
        if (HADDR !== ea || done !== 1'b0 || err !== 1'b0)
          $display("FAIL busy_beat b=%0d k=%0d: addr=%h done=%b err=%b want addr=%h done=0 err=0",
                   b, k, HADDR, done, err, ea);
        else passed++;
      end else begin
        if ({HTRANS, HADDR, HWRITE, HSIZE, HBURST, done, err} !== {et, ea, wr, 3'(sz), 3'(b), 2'b00})
          $display("FAIL beat b=%0d start=%h k=%0d: trans=%0d addr=%h wr=%b size=%0d burst=%0d done=%b err=%b want trans=%0d addr=%h wr=%b size=%0d burst=%0d",
                   b, start, k, HTRANS, HADDR, HWRITE, HSIZE, HBURST, done, err, et, ea, wr, sz, b);
        else passed++;
      end
      HREADY    = ($urandom_range(0, 99) >= stall_pct);
      beat_hold = ($urandom_range(0, 99) < hold_pct);
      if (HREADY && HTRANS[1]) k++;
      step();
      cyc++;
    end
    total++;
    if (cyc >= 2000 || done !== 1'b1 || HTRANS !== 2'b00)
      $display("FAIL burst_end b=%0d: cycles=%0d done=%b trans=%0d want done=1 trans=0", b, cyc, done, HTRANS);
    else passed++;
    HREADY = 1'b1; beat_hold = 1'b0;
    step();
    total++;
    if (done !== 1'b0 || req_ready !== 1'b1)
      $display("FAIL burst_after b=%0d: done=%b ready=%b want done=0 ready=1", b, done, req_ready);
    else passed++;
  endtask

  task automatic test_reset();
    HRESETn = 1'b0; req_valid = 1'b0; req_addr = '0; req_write = 1'b0; req_burst = '0;
    req_size = '0; req_len = '0; beat_hold = 1'b0; HREADY = 1'b1; HRESP = 1'b0;
    step(); step();
    total++;
    if ({HTRANS, HADDR, HWRITE, HSIZE, HBURST, done, err, req_ready} !== {2'b00, 32'h0, 1'b0, 3'd0, 3'd0, 3'b001})
      $display("FAIL reset: trans=%0d addr=%h wr=%b size=%0d burst=%0d done=%b err=%b ready=%b want all zero, ready=1",
               HTRANS, HADDR, HWRITE, HSIZE, HBURST, done, err, req_ready);
    else passed++;
    HRESETn = 1'b1;
    step();
  endtask

  task automatic test_wrap4();
    logic [31:0] ea [4] = '{32'h38, 32'h3C, 32'h30, 32'h34};
    logic [1:0]  et [4] = '{2'b10, 2'b11, 2'b11, 2'b11};
    HREADY = 1'b1; beat_hold = 1'b0;
    send_req(32'h38, 2, 2, 0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({HTRANS, HADDR, done} !== {et[i], ea[i], 1'b0})
        $display("FAIL wrap4 beat%0d: trans=%0d addr=%h done=%b want trans=%0d addr=%h done=0", i, HTRANS, HADDR, done, et[i], ea[i]);
      else passed++;
      step();
    end
    total++;
    if (done !== 1'b1 || HTRANS !== 2'b00) $display("FAIL wrap4_done: done=%b trans=%0d want 1/0", done, HTRANS);
    else passed++;
    step();
  endtask

  task automatic test_incr_boundary();
    logic [31:0] ea [6] = '{32'h3F8, 32'h3FC, 32'h400, 32'h404, 32'h408, 32'h40C};
    logic [1:0]  et [6] = '{2'b10, 2'b11, 2'b10, 2'b11, 2'b11, 2'b11};
    int ndone = 0;
    HREADY = 1'b1; beat_hold = 1'b0;
    send_req(32'h3F8, 1, 2, 6, 1'b0);
    for (int i = 0; i < 6; i++) begin
      total++;
      if ({HTRANS, HADDR} !== {et[i], ea[i]})
        $display("FAIL incr_1k beat%0d: trans=%0d addr=%h want trans=%0d addr=%h", i, HTRANS, HADDR, et[i], ea[i]);
      else passed++;
      if (done) ndone++;
      step();
    end
    if (done) ndone++;
    step();
    if (done) ndone++;
    total++;
    if (ndone != 1) $display("FAIL incr_1k_done: done pulses=%0d want 1", ndone);
    else passed++;
  endtask

  task automatic test_stall_busy();
    logic [1:0]  et [10] = '{2'b10, 2'b11, 2'b11, 2'b11, 2'b11, 2'b01, 2'b01, 2'b11, 2'b11, 2'b00};
    logic [31:0] ea [10] = '{32'h100, 32'h104, 32'h104, 32'h104, 32'h104, 32'h108, 32'h108, 32'h108, 32'h10C, 32'h0};
    logic        hr [10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic        bh [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    HREADY = 1'b1; beat_hold = 1'b0;
    send_req(32'h100, 3, 2, 0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      total++;
      if (i < 9) begin
        if ({HTRANS, HADDR, done} !== {et[i], ea[i], 1'b0})
          $display("FAIL stall_busy cyc%0d: trans=%0d addr=%h done=%b want trans=%0d addr=%h done=0", i, HTRANS, HADDR, done, et[i], ea[i]);
        else passed++;
      end else begin
        if (HTRANS !== 2'b00 || done !== 1'b1)
          $display("FAIL stall_busy_done: trans=%0d done=%b want 0/1", HTRANS, done);
        else passed++;
      end
      HREADY = hr[i]; beat_hold = bh[i];
      step();
    end
  endtask

  task automatic test_error();
    HREADY = 1'b1; beat_hold = 1'b0; HRESP = 1'b0;
    send_req(32'h200, 5, 2, 0, 1'b0);
    step(); step();
    total++;
    if ({HTRANS, HADDR} !== {2'b11, 32'h208}) $display("FAIL err_beat3: trans=%0d addr=%h want 3/208", HTRANS, HADDR);
    else passed++;
    HRESP = 1'b1; HREADY = 1'b0;
    step();
    total++;
    if ({HTRANS, err, done, req_ready} !== {2'b00, 3'b100})
      $display("FAIL err_abort: trans=%0d err=%b done=%b ready=%b want 0/1/0/0", HTRANS, err, done, req_ready);
    else passed++;
    HREADY = 1'b1;
    step();
    total++;
    if ({HTRANS, err, done, req_ready} !== {2'b00, 3'b001})
      $display("FAIL err_recover: trans=%0d err=%b done=%b ready=%b want 0/0/0/1", HTRANS, err, done, req_ready);
    else passed++;
    HREADY = 1'b0;
    step();
    total++;
    if (err !== 1'b0 || HTRANS !== 2'b00) $display("FAIL err_idle_ignored: err=%b trans=%0d want 0/0", err, HTRANS);
    else passed++;
    HRESP = 1'b0; HREADY = 1'b1;
    step();
  endtask

  task automatic test_illegal();
    logic [31:0] ia [5] = '{32'h3F8, 32'h101, 32'h0, 32'h0, 32'h0};
    int          ib [5] = '{3, 0, 0, 1, 1};
    int          is [5] = '{2, 1, 3, 2, 2};
    int          il [5] = '{0, 0, 0, 0, 17};
    for (int i = 0; i < 5; i++) begin
      send_req(ia[i], ib[i], is[i], il[i], 1'b0);
      total++;
      if ({err, HTRANS, req_ready} !== {1'b1, 2'b00, 1'b1})
        $display("FAIL illegal%0d: err=%b trans=%0d ready=%b want 1/0/1", i, err, HTRANS, req_ready);
      else passed++;
      step();
      total++;
      if ({err, HTRANS} !== {1'b0, 2'b00}) $display("FAIL illegal%0d_after: err=%b trans=%0d want 0/0", i, err, HTRANS);
      else passed++;
    end
  endtask

  task automatic test_reset_mid();
    HREADY = 1'b1; beat_hold = 1'b0; HRESP = 1'b0;
    send_req(32'h40, 7, 2, 0, 1'b1);
    step(); step(); step(); step();
    total++;
    if ({HTRANS, HADDR} !== {2'b11, 32'h50}) $display("FAIL rst_mid_beat5: trans=%0d addr=%h want 3/50", HTRANS, HADDR);
    else passed++;
    HRESETn = 1'b0;
    step();
    total++;
    if ({HTRANS, HADDR, HWRITE, HBURST, done, err, req_ready} !== {2'b00, 32'h0, 1'b0, 3'd0, 3'b001})
      $display("FAIL rst_mid: trans=%0d addr=%h wr=%b burst=%0d done=%b err=%b ready=%b want 0/0/0/0/0/0/1",
               HTRANS, HADDR, HWRITE, HBURST, done, err, req_ready);
    else passed++;
    HRESETn = 1'b1;
    run_burst(32'h0, 0, 2, 0, 1'b0, 0, 0);
  endtask

  task automatic test_random();
    int b, sz, len, nb;
    int unsigned a, span, off;
    for (int n = 0; n < 40; n++) begin
      b   = $urandom_range(0, 7);
      sz  = $urandom_range(0, 2);
      len = $urandom_range(1, ML);
      nb  = nbeats(b, len);
      a   = $urandom_range(0, 4095) & ~((32'd1 << sz) - 1);
      span = nb * (32'd1 << sz);
      off  = a % 1024;
      if ((b == 3 || b == 5 || b == 7) && off + span > 1024) a = a - (off + span - 1024);
      run_burst(a, b, sz, len, 1'($urandom_range(0, 1)), 25, 25);
    end
  endtask

  initial begin
    test_reset();
    test_wrap4();
    test_incr_boundary();
    test_stall_busy();
    test_error();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
